// File: rtl/pmp_pkg.sv
// pmp_pkg: shared definitions for the PMP CSR bank (writer) and the PMP
// address checker (reader).
//   - PMP_ENTRIES / XLEN / CFG_CSRS : fixed geometry (16 entries, 32-bit CSRs)
//   - pmp_a_e                       : address-matching mode encoding
//   - pmpcfg_t                      : one pmpNcfg byte
//   - CSR_PMPCFG0 / CSR_PMPADDR0    : base CSR addresses
//   - PRIV_M                        : machine privilege encoding
package pmp_pkg;

    localparam int PMP_ENTRIES = 16;
    localparam int XLEN        = 32;
    localparam int CFG_CSRS    = 4;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
    localparam logic [1:0]  PRIV_M       = 2'b11;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// pmp_cfg_legalize: combinational WARL legalization of one pmpNcfg byte.
//   old_cfg    : byte currently stored
//   new_cfg    : byte being written
//   stored_cfg : byte that must be stored
// A locked entry keeps its old value. Otherwise the reserved bits are
// cleared and the reserved R=0/W=1 combination is turned into R=0/W=0.
module pmp_cfg_legalize
    import pmp_pkg::*;
(
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    output logic [7:0] stored_cfg
);

    pmpcfg_t old_s;
    pmpcfg_t new_s;
    pmpcfg_t res_s;

    always_comb begin
        old_s = pmpcfg_t'(old_cfg);
        new_s = pmpcfg_t'(new_cfg);
        res_s = new_s;
        res_s.rsvd = 2'b00;
        if (!new_s.r && new_s.w) begin
            res_s.w = 1'b0;
        end
        if (old_s.l) begin
            res_s = old_s;
        end
        stored_cfg = res_s;
    end

endmodule

// File: rtl/pmp_csr_bank.sv
// pmp_csr_bank: machine-mode storage for pmpcfg0-3 and pmpaddr0-15.
//   clk, rst      : clock, synchronous active-high reset
//   csr_req/we    : access request, write when csr_we=1
//   csr_addr      : 12-bit CSR address
//   csr_wdata     : write data (already merged for set/clear ops)
//   prive_mode    : current privilege level
//   csr_hit       : combinational, address is a PMP CSR
//   csr_rvalid    : registered response strobe
//   csr_rdata     : registered read data (old value on writes)
//   csr_illegal   : registered, access attempted below M mode
//   pmpcfg_data   : pmpcfg0-3 packed, pmpcfg0 in the low word
//   pmpaddr_data  : pmpaddr0-15 packed, pmpaddr0 in the low word
//   pmp_changed   : one-cycle pulse with csr_rvalid when state really changed
//
// Handshake: a request is accepted in every cycle where csr_req is high and
// csr_hit is true (no backpressure); its response (csr_rvalid with
// csr_rdata/csr_illegal) appears exactly one cycle later. Requests that miss
// the PMP range produce no response.
module pmp_csr_bank
    import pmp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        csr_req,
    input  logic                        csr_we,
    input  logic [11:0]                 csr_addr,
    input  logic [XLEN-1:0]             csr_wdata,
    input  logic [1:0]                  prive_mode,
    output logic                        csr_hit,
    output logic                        csr_rvalid,
    output logic [XLEN-1:0]             csr_rdata,
    output logic                        csr_illegal,
    output logic [CFG_CSRS*XLEN-1:0]    pmpcfg_data,
    output logic [PMP_ENTRIES*XLEN-1:0] pmpaddr_data,
    output logic                        pmp_changed
);

    logic [XLEN-1:0] pmpcfg_q  [CFG_CSRS];
    logic [XLEN-1:0] pmpcfg_d  [CFG_CSRS];
    logic [XLEN-1:0] pmpaddr_q [PMP_ENTRIES];
    logic [XLEN-1:0] pmpaddr_d [PMP_ENTRIES];
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            illegal_q, illegal_d;
    logic            changed_q, changed_d;

    logic            is_cfg;
    logic            is_addr;
    logic            priv_ok;
    logic            access;
    logic            do_write;
    logic [1:0]      cfg_sel;
    logic [3:0]      ent;
    logic [3:0]      ent_nxt;
    logic [XLEN-1:0] cfg_old_word;
    logic [XLEN-1:0] legal_word;
    logic [XLEN-1:0] old_word;
    pmpcfg_t         ent_cfg;
    pmpcfg_t         nxt_cfg;
    logic            addr_locked;

    assign is_cfg   = (csr_addr[11:2] == CSR_PMPCFG0[11:2]);
    assign is_addr  = (csr_addr[11:4] == CSR_PMPADDR0[11:4]);
    assign csr_hit  = is_cfg | is_addr;
    assign priv_ok  = (prive_mode == PRIV_M);
    assign access   = csr_req & csr_hit;
    assign do_write = access & csr_we & priv_ok;

    assign cfg_sel      = csr_addr[1:0];
    assign ent          = csr_addr[3:0];
    assign ent_nxt      = ent + 4'd1;
    assign cfg_old_word = pmpcfg_q[cfg_sel];
    assign old_word     = is_cfg ? cfg_old_word : pmpaddr_q[ent];

    for (genvar g = 0; g < 4; g++) begin : g_legalize
        pmp_cfg_legalize u_legalize (
            .old_cfg    (cfg_old_word[8*g +: 8]),
            .new_cfg    (csr_wdata[8*g +: 8]),
            .stored_cfg (legal_word[8*g +: 8])
        );
    end

    // An address register is frozen by its own lock, or by the next entry
    // when that entry is locked TOR (it uses this register as its base).
    // Entry 15 has no successor, so the wrapped ent_nxt is masked off.
    assign ent_cfg     = pmpcfg_t'(pmpcfg_q[ent[3:2]][{ent[1:0], 3'b000} +: 8]);
    assign nxt_cfg     = pmpcfg_t'(pmpcfg_q[ent_nxt[3:2]][{ent_nxt[1:0], 3'b000} +: 8]);
    assign addr_locked = ent_cfg.l
                       | ((ent != 4'd15) & nxt_cfg.l & (nxt_cfg.a == A_TOR));

    always_comb begin
        pmpcfg_d  = pmpcfg_q;
        pmpaddr_d = pmpaddr_q;
        changed_d = 1'b0;
        if (do_write && is_cfg) begin
            pmpcfg_d[cfg_sel] = legal_word;
            changed_d         = (legal_word != cfg_old_word);
        end
        if (do_write && is_addr && !addr_locked) begin
            pmpaddr_d[ent] = csr_wdata;
            changed_d      = (csr_wdata != pmpaddr_q[ent]);
        end
        rvalid_d  = access;
        illegal_d = access & ~priv_ok;
        // Reads return pre-write contents; faulted accesses return zero.
        rdata_d   = (access && priv_ok) ? old_word : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CFG_CSRS; i++) begin
                pmpcfg_q[i] <= '0;
            end
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                pmpaddr_q[i] <= '0;
            end
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            pmpcfg_q  <= pmpcfg_d;
            pmpaddr_q <= pmpaddr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
            changed_q <= changed_d;
        end
    end

    for (genvar g = 0; g < CFG_CSRS; g++) begin : g_cfg_out
        assign pmpcfg_data[g*XLEN +: XLEN] = pmpcfg_q[g];
    end
    for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_addr_out
        assign pmpaddr_data[g*XLEN +: XLEN] = pmpaddr_q[g];
    end

    assign csr_rvalid  = rvalid_q;
    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;
    assign pmp_changed = changed_q;

endmodule

// File: tb/tb_pmp_csr_bank.sv
module tb_pmp_csr_bank;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         csr_req = 1'b0;
    logic         csr_we = 1'b0;
    logic [11:0]  csr_addr = '0;
    logic [31:0]  csr_wdata = '0;
    logic [1:0]   prive_mode = 2'b11;
    logic         csr_hit;
    logic         csr_rvalid;
    logic [31:0]  csr_rdata;
    logic         csr_illegal;
    logic [127:0] pmpcfg_data;
    logic [511:0] pmpaddr_data;
    logic         pmp_changed;

    always #5 clk = ~clk;

    pmp_csr_bank dut (
        .clk          (clk),
        .rst          (rst),
        .csr_req      (csr_req),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .prive_mode   (prive_mode),
        .csr_hit      (csr_hit),
        .csr_rvalid   (csr_rvalid),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .pmpcfg_data  (pmpcfg_data),
        .pmpaddr_data (pmpaddr_data),
        .pmp_changed  (pmp_changed)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_cfg  [16];
    logic [31:0] m_addr [16];
    logic [31:0] exp_q[$];
    logic        e_rvalid, e_illegal, e_changed;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 32'h0;
        end
        exp_q.delete();
    endtask

    function automatic logic [127:0] m_cfg_vec();
        logic [127:0] v;
        for (int e = 0; e < 16; e++) v[e*8 +: 8] = m_cfg[e];
        return v;
    endfunction

    function automatic logic [511:0] m_addr_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_addr[i];
        return v;
    endfunction

    task automatic model_access(input logic we, input logic [11:0] a,
                                input logic [31:0] d, input logic [1:0] p);
        int          k;
        logic        hit_c, hit_a, locked;
        logic [31:0] old;
        logic [7:0]  nb;
        hit_c     = (a >= 12'h3A0) && (a <= 12'h3A3);
        hit_a     = (a >= 12'h3B0) && (a <= 12'h3BF);
        e_rvalid  = hit_c || hit_a;
        e_illegal = e_rvalid && (p != 2'b11);
        e_changed = 1'b0;
        if (!e_rvalid) return;
        if (hit_c) begin
            k   = int'(a) - 'h3A0;
            old = {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
        end else begin
            k   = int'(a) - 'h3B0;
            old = m_addr[k];
        end
        exp_q.push_back((p == 2'b11) ? old : 32'h0);
        if (p != 2'b11 || !we) return;
        if (hit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (!m_cfg[4*k+b][7]) begin
                    nb = 8'((d >> (8 * b)) & 32'hFF);
                    nb[6:5] = 2'b00;
                    if (nb[0] == 1'b0 && nb[1] == 1'b1) nb[1] = 1'b0;
                    if (nb != m_cfg[4*k+b]) e_changed = 1'b1;
                    m_cfg[4*k+b] = nb;
                end
            end
        end else begin
            locked = m_cfg[k][7];
            if (k < 15) begin
                if (m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'b01) locked = 1'b1;
            end
            if (!locked && d != m_addr[k]) begin
                e_changed = 1'b1;
                m_addr[k] = d;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives one request, lets the DUT sample it, and returns #1 after the
    // edge with the response visible. Leaves csr_req low so a following
    // issue() call forms a back-to-back sequence.
    task automatic issue(input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [1:0] p);
        model_access(we, a, d, p);
        csr_req    = 1'b1;
        csr_we     = we;
        csr_addr   = a;
        csr_wdata  = d;
        prive_mode = p;
        @(posedge clk);
        #1;
        csr_req = 1'b0;
        csr_we  = 1'b0;
        exp_rdata = 32'h0;
        if (e_rvalid && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (pmpcfg_data !== 128'h0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", pmpcfg_data); end
        total++; if (pmpaddr_data !== 512'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pmpaddr_data); end
        total++; if (csr_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", csr_rvalid); end
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", csr_rdata); end
        total++; if (csr_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", csr_illegal); end
        total++; if (pmp_changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", pmp_changed); end
        rst = 1'b0;
        model_reset();
        issue(1'b0, 12'h3A0, 32'h0, 2'b11);
        total++; if (csr_rvalid !== 1'b1) begin bad++; $display("FAIL rd3a0_rvalid got=%b exp=1", csr_rvalid); end
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL rd3a0_rdata got=%h exp=0", csr_rdata); end
        issue(1'b0, 12'h3B5, 32'h0, 2'b11);
        total++; if (csr_rvalid !== 1'b1) begin bad++; $display("FAIL rd3b5_rvalid got=%b exp=1", csr_rvalid); end
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL rd3b5_rdata got=%h exp=0", csr_rdata); end
        total++; if (pmp_changed !== 1'b0) begin bad++; $display("FAIL rd3b5_changed got=%b exp=0", pmp_changed); end
    endtask

    task automatic test_cfg_legalize();
        issue(1'b1, 12'h3A0, 32'h0000_1F0B, 2'b11);
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL cfg_wr_old got=%h exp=0", csr_rdata); end
        total++; if (pmp_changed !== 1'b1) begin bad++; $display("FAIL cfg_wr_changed got=%b exp=1", pmp_changed); end
        total++; if (pmpcfg_data[31:0] !== 32'h0000_1F0B) begin bad++; $display("FAIL cfg_wr_state got=%h exp=00001f0b", pmpcfg_data[31:0]); end
        issue(1'b0, 12'h3A0, 32'h0, 2'b11);
        total++; if (csr_rdata !== 32'h0000_1F0B) begin bad++; $display("FAIL cfg_rd got=%h exp=00001f0b", csr_rdata); end
        // reserved bits cleared, R=0/W=1 fixed, lock stored as written
        issue(1'b1, 12'h3A1, 32'h6AFE_7E02, 2'b11);
        total++; if (pmpcfg_data[63:32] !== 32'h089C_1C00) begin bad++; $display("FAIL cfg1_legal got=%h exp=089c1c00", pmpcfg_data[63:32]); end
        total++; if (pmp_changed !== 1'b1) begin bad++; $display("FAIL cfg1_changed got=%b exp=1", pmp_changed); end
    endtask

    task automatic test_lock();
        issue(1'b1, 12'h3A0, 32'h0000_0082, 2'b11);
        total++; if (pmpcfg_data[31:0] !== 32'h0000_0080) begin bad++; $display("FAIL lock_set got=%h exp=00000080", pmpcfg_data[31:0]); end
        total++; if (csr_rdata !== 32'h0000_1F0B) begin bad++; $display("FAIL lock_set_old got=%h exp=00001f0b", csr_rdata); end
        issue(1'b1, 12'h3A0, 32'h0, 2'b11);
        total++; if (pmpcfg_data[31:0] !== 32'h0000_0080) begin bad++; $display("FAIL lock_hold got=%h exp=00000080", pmpcfg_data[31:0]); end
        total++; if (pmp_changed !== 1'b0) begin bad++; $display("FAIL lock_hold_changed got=%b exp=0", pmp_changed); end
        issue(1'b1, 12'h3A0, 32'h0000_007F, 2'b11);
        total++; if (pmpcfg_data[7:0] !== 8'h80) begin bad++; $display("FAIL lock_sticky got=%h exp=80", pmpcfg_data[7:0]); end
        issue(1'b1, 12'h3B0, 32'h0000_1234, 2'b11);
        total++; if (pmpaddr_data[31:0] !== 32'h0) begin bad++; $display("FAIL lock_addr0 got=%h exp=0", pmpaddr_data[31:0]); end
        total++; if (pmp_changed !== 1'b0) begin bad++; $display("FAIL lock_addr0_changed got=%b exp=0", pmp_changed); end
    endtask

    task automatic test_tor_lock();
        do_reset();
        issue(1'b1, 12'h3A0, 32'h0000_8809, 2'b11);
        total++; if (pmpcfg_data[31:0] !== 32'h0000_8809) begin bad++; $display("FAIL tor_cfg got=%h exp=00008809", pmpcfg_data[31:0]); end
        issue(1'b1, 12'h3B0, 32'h0000_1000, 2'b11);
        total++; if (pmpaddr_data[31:0] !== 32'h0) begin bad++; $display("FAIL tor_addr0 got=%h exp=0", pmpaddr_data[31:0]); end
        issue(1'b1, 12'h3B2, 32'h0000_2000, 2'b11);
        total++; if (pmpaddr_data[95:64] !== 32'h2000) begin bad++; $display("FAIL tor_addr2 got=%h exp=2000", pmpaddr_data[95:64]); end
        total++; if (pmp_changed !== 1'b1) begin bad++; $display("FAIL tor_addr2_changed got=%b exp=1", pmp_changed); end
        issue(1'b1, 12'h3B1, 32'h0000_3333, 2'b11);
        total++; if (pmpaddr_data[63:32] !== 32'h0) begin bad++; $display("FAIL tor_addr1_own got=%h exp=0", pmpaddr_data[63:32]); end
        // lock entry 0 as TOR: must not freeze pmpaddr15 via wrap-around
        issue(1'b1, 12'h3A0, 32'h9800_8889, 2'b11);
        total++; if (pmpcfg_data[31:0] !== 32'h9800_8889) begin bad++; $display("FAIL tor_cfg2 got=%h exp=98008889", pmpcfg_data[31:0]); end
        issue(1'b1, 12'h3BF, 32'h0000_DEAD, 2'b11);
        total++; if (pmpaddr_data[511:480] !== 32'hDEAD) begin bad++; $display("FAIL tor_addr15 got=%h exp=dead", pmpaddr_data[511:480]); end
        // entry 3 is locked NAPOT, which does not freeze pmpaddr2
        issue(1'b1, 12'h3B2, 32'h0000_3000, 2'b11);
        total++; if (pmpaddr_data[95:64] !== 32'h3000) begin bad++; $display("FAIL napot_addr2 got=%h exp=3000", pmpaddr_data[95:64]); end
        issue(1'b1, 12'h3B3, 32'h0000_4000, 2'b11);
        total++; if (pmpaddr_data[127:96] !== 32'h0) begin bad++; $display("FAIL napot_addr3 got=%h exp=0", pmpaddr_data[127:96]); end
    endtask

    task automatic test_priv();
        do_reset();
        issue(1'b1, 12'h3B3, 32'h0000_0055, 2'b11);
        issue(1'b1, 12'h3B3, 32'hFFFF_FFFF, 2'b00);
        total++; if (csr_rvalid !== 1'b1) begin bad++; $display("FAIL priv_rvalid got=%b exp=1", csr_rvalid); end
        total++; if (csr_illegal !== 1'b1) begin bad++; $display("FAIL priv_illegal got=%b exp=1", csr_illegal); end
        total++; if (csr_rdata !== 32'h0) begin bad++; $display("FAIL priv_rdata got=%h exp=0", csr_rdata); end
        total++; if (pmpaddr_data[127:96] !== 32'h55) begin bad++; $display("FAIL priv_state got=%h exp=55", pmpaddr_data[127:96]); end
        total++; if (pmp_changed !== 1'b0) begin bad++; $display("FAIL priv_changed got=%b exp=0", pmp_changed); end
        issue(1'b0, 12'h3B3, 32'h0, 2'b01);
        total++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin bad++; $display("FAIL priv_srd got=%h/%b exp=0/1", csr_rdata, csr_illegal); end
        issue(1'b0, 12'h3B3, 32'h0, 2'b11);
        total++; if (csr_rdata !== 32'h55 || csr_illegal !== 1'b0) begin bad++; $display("FAIL priv_mrd got=%h/%b exp=55/0", csr_rdata, csr_illegal); end
    endtask

    task automatic test_miss();
        logic [11:0] miss_tab [6] = '{12'h3A4, 12'h3AF, 12'h3C0, 12'h39F, 12'h300, 12'h7A0};
        for (int i = 0; i < 6; i++) begin
            csr_addr = miss_tab[i];
            #1;
            total++; if (csr_hit !== 1'b0) begin bad++; $display("FAIL miss_hit addr=%h got=%b exp=0", miss_tab[i], csr_hit); end
            issue(1'b1, miss_tab[i], 32'hFFFF_FFFF, 2'b11);
            total++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0) begin bad++; $display("FAIL miss_resp addr=%h got=%b/%b exp=0/0", miss_tab[i], csr_rvalid, csr_illegal); end
            total++; if (pmpaddr_data !== m_addr_vec() || pmpcfg_data !== m_cfg_vec()) begin bad++; $display("FAIL miss_state addr=%h", miss_tab[i]); end
        end
        csr_addr = 12'h3BF;
        #1;
        total++; if (csr_hit !== 1'b1) begin bad++; $display("FAIL hit_3bf got=%b exp=1", csr_hit); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(1'b1, 12'h3B7, 32'h0000_00AA, 2'b11);
        total++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0 || pmp_changed !== 1'b1) begin bad++; $display("FAIL b2b_wr got=%b/%h/%b exp=1/0/1", csr_rvalid, csr_rdata, pmp_changed); end
        issue(1'b0, 12'h3B7, 32'h0, 2'b11);
        total++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'hAA || pmp_changed !== 1'b0) begin bad++; $display("FAIL b2b_rd got=%b/%h/%b exp=1/aa/0", csr_rvalid, csr_rdata, pmp_changed); end
        issue(1'b1, 12'h3A1, 32'h0000_0080, 2'b11);
        // reset wins over a same-cycle write
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B9; csr_wdata = 32'h1234_5678; rst = 1'b1;
        @(posedge clk);
        #1;
        csr_req = 1'b0; csr_we = 1'b0; rst = 1'b0;
        model_reset();
        total++; if (pmpaddr_data !== 512'h0 || pmpcfg_data !== 128'h0) begin bad++; $display("FAIL rst_during_wr state not cleared"); end
        total++; if (csr_rvalid !== 1'b0 || pmp_changed !== 1'b0) begin bad++; $display("FAIL rst_during_wr_resp got=%b/%b exp=0/0", csr_rvalid, pmp_changed); end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d;
        logic [1:0]  p;
        logic        we;
        int          sel;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)       a = 12'h3A0 + 12'($urandom_range(0, 3));
            else if (sel < 9)  a = 12'h3B0 + 12'($urandom_range(0, 15));
            else               a = 12'($urandom_range(12'h390, 12'h3CF));
            d = $urandom;
            if (sel < 3 && $urandom_range(0, 5) != 0) d = d & 32'h7F7F_7F7F;
            p  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            we = ($urandom_range(0, 2) != 0);
            issue(we, a, d, p);
            total++; if (csr_rvalid !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid n=%0d addr=%h got=%b exp=%b", n, a, csr_rvalid, e_rvalid); end
            total++; if (csr_illegal !== e_illegal) begin bad++; $display("FAIL rnd_illegal n=%0d addr=%h got=%b exp=%b", n, a, csr_illegal, e_illegal); end
            total++; if (pmp_changed !== e_changed) begin bad++; $display("FAIL rnd_changed n=%0d addr=%h got=%b exp=%b", n, a, pmp_changed, e_changed); end
            if (e_rvalid) begin
                total++; if (csr_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, a, csr_rdata, exp_rdata); end
            end
            total++; if (pmpcfg_data !== m_cfg_vec()) begin bad++; $display("FAIL rnd_cfg n=%0d got=%h exp=%h", n, pmpcfg_data, m_cfg_vec()); end
            total++; if (pmpaddr_data !== m_addr_vec()) begin bad++; $display("FAIL rnd_addr n=%0d addr=%h", n, a); end
            if ($urandom_range(0, 99) == 0) do_reset();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_cfg_legalize();
        test_lock();
        test_tor_lock();
        test_priv();
        test_miss();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
